// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle ops plus a 32-cycle shift-add multiplier that stalls the pipeline.
// Define ALU_FAST_MUL_EN to replace the iterative multiplier with a single-cycle combinational multiply.
module alu_mc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [3:0]  ALUCtl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [31:0] data_o,
    output logic        zero_o,
    output logic        lt_o,
    output logic        stall_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTL_W  = 4;
    localparam int unsigned SHA_W  = 5;

    localparam logic [CTL_W-1:0] ALU_CTL_ADD  = 4'd0;
    localparam logic [CTL_W-1:0] ALU_CTL_SUB  = 4'd1;
    localparam logic [CTL_W-1:0] ALU_CTL_SUBU = 4'd2;
    localparam logic [CTL_W-1:0] ALU_CTL_SLL  = 4'd3;
    localparam logic [CTL_W-1:0] ALU_CTL_SRL  = 4'd4;
    localparam logic [CTL_W-1:0] ALU_CTL_SRA  = 4'd5;
    localparam logic [CTL_W-1:0] ALU_CTL_XOR  = 4'd6;
    localparam logic [CTL_W-1:0] ALU_CTL_AND  = 4'd7;
    localparam logic [CTL_W-1:0] ALU_CTL_MUL  = 4'd8;

    logic [DATA_W:0]   sub_ext;
    logic [DATA_W-1:0] diff;
    logic              borrow;
    logic [SHA_W-1:0]  shamt;
    logic [DATA_W-1:0] alu_res;

    // Borrow-extended subtract shared by SUB/SUBU and the SUBU borrow flag
    assign sub_ext = {1'b0, data1_i} - {1'b0, data2_i};
    assign diff    = sub_ext[DATA_W-1:0];
    assign borrow  = sub_ext[DATA_W];
    assign shamt   = data2_i[SHA_W-1:0];

    // Single-cycle result for the current operation code
    always_comb begin : alu_comb
        alu_res = data1_i + data2_i;
        case (ALUCtl_i)
            ALU_CTL_ADD:  alu_res = data1_i + data2_i;
            ALU_CTL_SUB:  alu_res = diff;
            ALU_CTL_SUBU: alu_res = diff;
            ALU_CTL_SLL:  alu_res = data1_i << shamt;
            ALU_CTL_SRL:  alu_res = data1_i >> shamt;
            ALU_CTL_SRA:  alu_res = DATA_W'($signed(data1_i) >>> shamt);
            ALU_CTL_XOR:  alu_res = data1_i ^ data2_i;
            ALU_CTL_AND:  alu_res = data1_i & data2_i;
`ifdef ALU_FAST_MUL_EN
            ALU_CTL_MUL:  alu_res = data1_i * data2_i;
`else
            ALU_CTL_MUL:  alu_res = '0;
`endif
            default:      alu_res = data1_i + data2_i;
        endcase
    end

`ifdef ALU_FAST_MUL_EN

    logic unused_fast;
    assign unused_fast = ^{clk_i, rst_i, flush_i, valid_i};

    assign data_o  = alu_res;
    assign stall_o = 1'b0;

`else

    localparam int unsigned CNT_W    = 6;
    localparam int unsigned LAST_CNT = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] product;
    logic              mul_start;

    assign mul_start = valid_i && (ALUCtl_i == ALU_CTL_MUL) && !flush_i;

    // Iterative shift-add multiplier sequencing
    always_ff @(posedge clk_i) begin : mul_fsm
        if (rst_i) begin
            state   <= ST_IDLE;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        mcand   <= data1_i;
                        mplier  <= data2_i;
                        product <= '0;
                        count   <= '0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        product <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        if (mplier[0]) begin
                            product <= product + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + CNT_W'(1);
                        if (count == CNT_W'(LAST_CNT)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (flush_i) begin
                        product <= '0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result mux and stall; stall depends combinationally on the start condition in IDLE
    always_comb begin : mul_out
        stall_o = 1'b0;
        data_o  = alu_res;
        case (state)
            ST_IDLE: begin
                if (mul_start) begin
                    stall_o = 1'b1;
                    data_o  = '0;
                end
            end
            ST_BUSY: begin
                stall_o = 1'b1;
                data_o  = product;
            end
            ST_DONE: begin
                data_o = product;
            end
            default: begin
                stall_o = 1'b0;
                data_o  = alu_res;
            end
        endcase
        if (rst_i) begin
            stall_o = 1'b0;
        end
    end

`endif

    // Branch flags follow whatever is on data_o this cycle
    assign zero_o = (data_o == '0);

    always_comb begin : flag_comb
        lt_o = 1'b0;
        case (ALUCtl_i)
            ALU_CTL_SUB:  lt_o = (data1_i[DATA_W-1] != data2_i[DATA_W-1]) ? data1_i[DATA_W-1]
                                                                           : data_o[DATA_W-1];
            ALU_CTL_SUBU: lt_o = borrow;
            default:      lt_o = 1'b0;
        endcase
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle ALU for the EX stage, directly downstream of the ALU control decoder. It consumes the 4-bit `ALU_CTL_*` code and the two operands and produces the result and branch flags. Every operation completes in a single cycle except `ALU_CTL_MUL`, which runs an iterative shift-add multiplier and asserts `stall_o` so the hazard unit freezes the pipeline until the product is ready.

## Interface
- No parameters; data width is fixed at 32 and codes come from `Const.v`.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  EX flush; aborts any multiply in progress.
- valid_i  in  1  EX holds a live instruction.
- ALUCtl_i  in  4  `ALU_CTL_*` operation code.
- data1_i  in  32  operand A (rs1).
- data2_i  in  32  operand B (rs2 or immediate).
- data_o  out  32  result.
- zero_o  out  1  `data_o == 0`.
- lt_o  out  1  A < B: signed for SUB, unsigned for SUBU, 0 otherwise.
- stall_o  out  1  freeze IF/ID/EX; inputs must stay stable while high.

## Operation
- States: IDLE, BUSY, DONE. Registers: state, 6-bit count, 32-bit multiplicand, 32-bit multiplier, 32-bit product.
- IDLE, non-MUL (or `valid_i` = 0): `data_o` is combinational from the inputs.
  - ADD, SUB, SUBU: A+B, A−B, A−B.
  - SLL, SRL: shift A by B[4:0]; SRA: arithmetic shift of A by B[4:0].
  - XOR, AND: bitwise.
  - Any unlisted code computes ADD.
  - `stall_o` = 0.
- IDLE, `valid_i` && MUL && !`flush_i`:
  - `stall_o` = 1 combinationally in the same cycle; `data_o` = 0.
  - Capture A into multiplicand and B into multiplier; clear product; count ← 0; go to BUSY.
- BUSY, each cycle:
  - If multiplier[0]: product ← product + multiplicand (mod 2^32).
  - Multiplicand <<= 1; multiplier >>= 1; count++.
  - After the 32nd BUSY cycle (count = 31 at the edge), go to DONE.
  - `stall_o` = 1 throughout; `data_o` = product.
- DONE:
  - `stall_o` = 0 and `data_o` = product, independent of the current inputs. The pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally.
- MUL returns the low 32 bits of the product, which are the same for signed and unsigned operands.
- `zero_o` and `lt_o` are always derived from the current `data_o` and the current code. For SUB, `lt_o` is sign-corrected: (A[31]≠B[31]) ? A[31] : diff[31]. For SUBU, `lt_o` is the borrow out.
- `flush_i` in BUSY or DONE: next state is IDLE; the product is discarded.
- `flush_i` together with a MUL start in IDLE: flush wins and no start occurs.
- Reset (including mid-multiply): state IDLE, count 0, all datapath registers 0. `stall_o` is forced to 0 while `rst_i` is high.

## Timing
- Non-MUL: 0-cycle latency (combinational); EX residency is 1 cycle.
- MUL: 1 IDLE (start) + 32 BUSY + 1 DONE = 34-cycle EX residency. `stall_o` is high for exactly the first 33 of those cycles.
- Back-to-back MULs: the second MUL enters in the IDLE cycle right after DONE and starts immediately, so there are no idle bubbles.
- `stall_o` depends combinationally on `valid_i`, `ALUCtl_i` and `flush_i` in IDLE. The hazard unit must not feed `stall_o` back into those inputs combinationally.
- No reset-to-output latency beyond the next clock edge.

## Configuration
- `ALU_FAST_MUL_EN` defined:
  - MUL is a single-cycle combinational 32×32 → low-32 multiply.
  - BUSY and DONE are never entered and `stall_o` is tied to 0.
  - The state and datapath registers may be omitted.
- `ALU_FAST_MUL_EN` undefined: the iterative 34-cycle behaviour above. This is the default.

## Test plan
- ADD with A=5, B=7 -> `data_o`=12 in the same cycle, `stall_o`=0, `zero_o`=0.
- Branch flags:
  - SUB with A=3, B=3 -> `zero_o`=1, `lt_o`=0.
  - SUB with A=1, B=0xFFFFFFFF -> `lt_o`=0.
  - SUBU with A=1, B=0xFFFFFFFF -> `lt_o`=1.
- Shifts:
  - SRA with A=0x80000000, B=4 -> 0xF8000000.
  - SRL with the same operands -> 0x08000000.
  - SLL with A=1, B=0x21 -> 0x00000002 (only B[4:0] is used).
- MUL with A=0xFFFFFFFF, B=3, inputs held -> `stall_o` high for exactly 33 cycles; the next cycle shows `stall_o`=0 and `data_o`=0xFFFFFFFD; the following cycle returns to IDLE.
- `flush_i` pulsed in the 10th BUSY cycle -> `stall_o`=0 on the next cycle and state IDLE. Repeat the multiply and pulse `rst_i` mid-multiply instead -> same abort behaviour, and the next MUL (6×7) yields 42.
- Back-to-back MUL 6×7 then 0x00010000×0x00010000 -> 42, then 0 (overflow truncated), with no gap between the two 34-cycle windows. Rerun with `ALU_FAST_MUL_EN` defined -> both results appear in consecutive cycles and `stall_o` is never asserted.
